ram_burst_requester: RTL and testbench

- Initiator for the team's single-port, busy-handshaked word RAM interface (addr/wdata/byte_en/wen/ren in; rdata/busy out).
- Accepts one burst command at a time (start word address, beat count, direction). Streams write beats in and read beats out over valid/ready.
- Holds every RAM request stable until the RAM signals completion.
- Sits between cache line-fill/writeback logic and the RAM port.

---
 rtl/ram_burst_requester.sv | 183 ++++++++++++++++++
 tb/tb_ram_burst_requester.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_requester.sv
// Burst initiator for the single-port busy-handshaked word RAM: takes one burst command,
// streams write beats in / read beats out, and holds each RAM request until busy drops.
module ram_burst_requester #(
  parameter int N_BYTES   = 4,
  parameter int N_BITS    = N_BYTES * 8,
  parameter int ADDR_BITS = 13,
  parameter int LEN_BITS  = 4,
  parameter int TIMEOUT   = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]  cmd_len,
  input  logic                 wbeat_valid,
  output logic                 wbeat_ready,
  input  logic [N_BITS-1:0]    wbeat_data,
  input  logic [N_BYTES-1:0]   wbeat_byte_en,
  output logic                 rbeat_valid,
  input  logic                 rbeat_ready,
  output logic [N_BITS-1:0]    rbeat_data,
  output logic                 rbeat_last,
  output logic                 cmd_done,
  output logic                 cmd_err,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [N_BITS-1:0]    ram_wdata,
  output logic [N_BYTES-1:0]   ram_byte_en,
  output logic                 ram_wen,
  output logic                 ram_ren,
  input  logic [N_BITS-1:0]    ram_rdata,
  input  logic                 ram_busy
);

  // All handshakes are valid/ready: a transfer happens at a rising edge where both are high,
  // and the sender keeps valid and payload stable until that edge.

  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_WAIT = 3'd1,
    WR_REQ  = 3'd2,
    RD_REQ  = 3'd3,
    RD_HOLD = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [LEN_BITS-1:0]  beat_q, beat_d;
  logic [N_BITS-1:0]    wdata_q, wdata_d;
  logic [N_BYTES-1:0]   be_q, be_d;
  logic [N_BITS-1:0]    rdata_q, rdata_d;
  logic                 rlast_q, rlast_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 timed_out;

  // A completing beat (busy low) always wins over a timeout on the same edge.
  assign timed_out = (TIMEOUT > 0) && ram_busy && (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    rlast_d  = rlast_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    to_cnt_d = to_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          len_d    = cmd_len;
          beat_d   = '0;
          to_cnt_d = '0;
          state_d  = cmd_write ? WR_WAIT : RD_REQ;
        end
      end
      WR_WAIT: begin
        if (wbeat_valid) begin
          wdata_d  = wbeat_data;
          be_d     = wbeat_byte_en;
          to_cnt_d = '0;
          state_d  = WR_REQ;
        end
      end
      WR_REQ: begin
        if (!ram_busy) begin
          if (beat_q == len_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = WR_WAIT;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT > 0) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      RD_REQ: begin
        if (!ram_busy) begin
          rdata_d = ram_rdata;
          rlast_d = (beat_q == len_q);
          state_d = RD_HOLD;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT > 0) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      RD_HOLD: begin
        if (rbeat_ready) begin
          if (rlast_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d   = beat_q + 1'b1;
            addr_d   = addr_q + 1'b1;
            to_cnt_d = '0;
            state_d  = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      rlast_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      rlast_q  <= rlast_d;
      done_q   <= done_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Requests decode straight from state so reset removes them without waiting for a clock.
  assign cmd_ready   = (state_q == IDLE);
  assign wbeat_ready = (state_q == WR_WAIT);
  assign ram_wen     = (state_q == WR_REQ);
  assign ram_ren     = (state_q == RD_REQ);
  assign rbeat_valid = (state_q == RD_HOLD);
  assign rbeat_data  = rdata_q;
  assign rbeat_last  = rlast_q;
  assign cmd_done    = done_q;
  assign cmd_err     = err_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign ram_byte_en = be_q;

endmodule

// File: tb/tb_ram_burst_requester.sv
// Directed bench for ram_burst_requester: behavioural busy-handshaked RAM, expected-data queue,
// and a linear sequence of read/write/wrap/timeout/reset scenarios.
module tb_ram_burst_requester;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [12:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic        wbeat_valid = 1'b0;
  logic        wbeat_ready;
  logic [31:0] wbeat_data = '0;
  logic [3:0]  wbeat_byte_en = '0;
  logic        rbeat_valid;
  logic        rbeat_ready = 1'b0;
  logic [31:0] rbeat_data;
  logic        rbeat_last;
  logic        cmd_done;
  logic        cmd_err;
  logic [12:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byte_en;
  logic        ram_wen;
  logic        ram_ren;
  logic [31:0] ram_rdata;
  logic        ram_busy;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  wbe_q[$];

  ram_burst_requester #(
    .N_BYTES(4), .N_BITS(32), .ADDR_BITS(13), .LEN_BITS(4), .TIMEOUT(8)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wbeat_valid(wbeat_valid), .wbeat_ready(wbeat_ready),
    .wbeat_data(wbeat_data), .wbeat_byte_en(wbeat_byte_en),
    .rbeat_valid(rbeat_valid), .rbeat_ready(rbeat_ready),
    .rbeat_data(rbeat_data), .rbeat_last(rbeat_last),
    .cmd_done(cmd_done), .cmd_err(cmd_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byte_en(ram_byte_en),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_rdata(ram_rdata), .ram_busy(ram_busy)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- RAM model ----------------
  logic [31:0] mem [0:8191];
  int          lat = 0;
  logic        stuck = 1'b0;
  int          bcnt = 0;

  assign ram_busy  = stuck | ((ram_wen | ram_ren) && (bcnt < lat));
  assign ram_rdata = mem[ram_addr];

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 32'h0;
      mem[13'h010] <= 32'hDEADBEEF;
      mem[13'h100] <= 32'd1;
      mem[13'h101] <= 32'd2;
      mem[13'h102] <= 32'd3;
      mem[13'h103] <= 32'd4;
      mem[13'h020] <= 32'hFFFFFFFF;
      mem[13'h021] <= 32'hFFFFFFFF;
      mem[13'h1FFF] <= 32'hA0A0A0A0;
      mem[13'h000] <= 32'hB1B1B1B1;
      mem[13'h001] <= 32'hC2C2C2C2;
      mem[13'h060] <= 32'h5A5A5A5A;
      bcnt <= 0;
    end else begin
      if (ram_wen && !ram_busy)
        for (int b = 0; b < 4; b++)
          if (ram_byte_en[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      if ((ram_wen | ram_ren) && ram_busy) bcnt <= bcnt + 1;
      else bcnt <= 0;
    end
  end

  // ---------------- protocol monitor ----------------
  logic        prev_req = 1'b0;
  logic [12:0] prev_addr = '0;
  int          viol = 0;
  int          overlap = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [12:0] addr_log[$];

  always @(posedge CLK) begin
    if ((ram_wen | ram_ren) && !prev_req) addr_log.push_back(ram_addr);
    if ((ram_wen | ram_ren) && prev_req && ram_addr != prev_addr) viol++;
    if (ram_wen && ram_ren) viol++;
    if (cmd_done && cmd_err) overlap++;
    if (cmd_done) done_cnt++;
    if (cmd_err) err_cnt++;
    prev_req  = ram_wen | ram_ren;
    prev_addr = ram_addr;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [12:0] a, input logic [3:0] l);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge CLK);
    cmd_valid = 1'b0;
    chk("cmd_taken", 32'(cmd_ready), 32'd0);
  endtask

  task automatic read_burst(input string tag, input logic [3:0] l, input int hold_beat,
                            input int hold_n);
    logic [31:0] e;
    for (int b = 0; b <= int'(l); b++) begin
      int t = 0;
      while (!rbeat_valid && t < 40) begin
        @(negedge CLK);
        t++;
      end
      chk({tag, "_rvalid"}, 32'(rbeat_valid), 32'd1);
      if (!rbeat_valid) return;
      e = exp_q.pop_front();
      chk({tag, "_ren_hold"}, 32'(ram_ren), 32'd0);
      chk({tag, "_data"}, rbeat_data, e);
      chk({tag, "_last"}, 32'(rbeat_last), 32'(b == int'(l)));
      if (b == hold_beat) begin
        repeat (hold_n) begin
          @(negedge CLK);
          chk({tag, "_hold_valid"}, 32'(rbeat_valid), 32'd1);
          chk({tag, "_hold_ren"}, 32'(ram_ren), 32'd0);
          chk({tag, "_hold_data"}, rbeat_data, e);
        end
      end
      rbeat_ready = 1'b1;
      @(negedge CLK);
      rbeat_ready = 1'b0;
      if (b == int'(l)) begin
        chk({tag, "_done"}, 32'(cmd_done), 32'd1);
        chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
      end else begin
        chk({tag, "_valid_drop"}, 32'(rbeat_valid), 32'd0);
      end
    end
    @(negedge CLK);
    chk({tag, "_done_pulse"}, 32'(cmd_done), 32'd0);
  endtask

  task automatic write_burst(input string tag, input logic [12:0] a, input logic [3:0] l);
    for (int b = 0; b <= int'(l); b++) begin
      int t = 0;
      logic [31:0] d;
      logic [3:0]  be;
      while (!wbeat_ready && t < 40) begin
        @(negedge CLK);
        t++;
      end
      chk({tag, "_wready"}, 32'(wbeat_ready), 32'd1);
      if (!wbeat_ready) return;
      chk({tag, "_wen_idle"}, 32'(ram_wen), 32'd0);
      d  = wd_q.pop_front();
      be = wbe_q.pop_front();
      wbeat_valid   = 1'b1;
      wbeat_data    = d;
      wbeat_byte_en = be;
      @(negedge CLK);
      wbeat_valid = 1'b0;
      chk({tag, "_wen"}, 32'(ram_wen), 32'd1);
      chk({tag, "_addr"}, 32'(ram_addr), 32'(13'(a + 13'(b))));
      chk({tag, "_wdata"}, ram_wdata, d);
      chk({tag, "_be"}, 32'(ram_byte_en), 32'(be));
      t = 0;
      while (ram_wen && t < 40) begin
        @(negedge CLK);
        t++;
      end
      chk({tag, "_wen_drop"}, 32'(ram_wen), 32'd0);
      if (b == int'(l)) chk({tag, "_done"}, 32'(cmd_done), 32'd1);
      else chk({tag, "_next_wready"}, 32'(wbeat_ready), 32'd1);
    end
    @(negedge CLK);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int idx;
    int n_ren;
    int snap_done;

    repeat (2) @(negedge CLK);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wen", 32'(ram_wen), 32'd0);
    chk("rst_ren", 32'(ram_ren), 32'd0);
    chk("rst_rvalid", 32'(rbeat_valid), 32'd0);
    chk("rst_wready", 32'(wbeat_ready), 32'd0);
    chk("rst_done", 32'(cmd_done), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // single-beat read, zero-latency RAM
    lat = 0;
    exp_q.push_back(32'hDEADBEEF);
    send_cmd(1'b0, 13'h010, 4'd0);
    chk("rd1_ren", 32'(ram_ren), 32'd1);
    chk("rd1_addr", 32'(ram_addr), 32'h010);
    read_burst("rd1", 4'd0, -1, 0);

    // 4-beat read, latency 3, consumer stalls 5 cycles on second beat
    lat = 3;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd4);
    send_cmd(1'b0, 13'h100, 4'd3);
    read_burst("rd4", 4'd3, 1, 5);

    // 2-beat write with partial byte enables, then read back
    lat = 2;
    wd_q.push_back(32'hAABBCCDD);
    wbe_q.push_back(4'b0011);
    wd_q.push_back(32'h11223344);
    wbe_q.push_back(4'hF);
    send_cmd(1'b1, 13'h020, 4'd1);
    write_burst("wr2", 13'h020, 4'd1);
    lat = 1;
    exp_q.push_back(32'hFFFFCCDD);
    exp_q.push_back(32'h11223344);
    send_cmd(1'b0, 13'h020, 4'd1);
    read_burst("rb2", 4'd1, -1, 0);

    // address wrap across the top of the RAM
    lat = 0;
    idx = addr_log.size();
    exp_q.push_back(32'hA0A0A0A0);
    exp_q.push_back(32'hB1B1B1B1);
    exp_q.push_back(32'hC2C2C2C2);
    send_cmd(1'b0, 13'h1FFF, 4'd2);
    read_burst("wrap", 4'd2, -1, 0);
    chk("wrap_nreq", 32'(addr_log.size() - idx), 32'd3);
    if (addr_log.size() >= idx + 3) begin
      chk("wrap_a0", 32'(addr_log[idx]), 32'h1FFF);
      chk("wrap_a1", 32'(addr_log[idx+1]), 32'h0000);
      chk("wrap_a2", 32'(addr_log[idx+2]), 32'h0001);
    end

    // busy stuck high: abort after 8 cycles of request
    stuck = 1'b1;
    snap_done = done_cnt;
    send_cmd(1'b0, 13'h040, 4'd0);
    n_ren = 0;
    for (int i = 0; i < 20; i++) begin
      if (!ram_ren) break;
      chk("to_rvalid", 32'(rbeat_valid), 32'd0);
      n_ren++;
      @(negedge CLK);
    end
    chk("to_ren_cycles", 32'(n_ren), 32'd8);
    chk("to_err", 32'(cmd_err), 32'd1);
    chk("to_ren_drop", 32'(ram_ren), 32'd0);
    chk("to_no_done", 32'(cmd_done), 32'd0);
    chk("to_ready", 32'(cmd_ready), 32'd1);
    stuck = 1'b0;
    @(negedge CLK);
    chk("to_err_pulse", 32'(cmd_err), 32'd0);
    chk("to_no_rvalid", 32'(rbeat_valid), 32'd0);
    chk("to_done_cnt", 32'(done_cnt), 32'(snap_done));

    // reset mid WR_REQ of a 4-beat write
    lat = 4;
    send_cmd(1'b1, 13'h060, 4'd3);
    chk("rstw_wready", 32'(wbeat_ready), 32'd1);
    wbeat_valid   = 1'b1;
    wbeat_data    = 32'h01020304;
    wbeat_byte_en = 4'hF;
    @(negedge CLK);
    wbeat_valid = 1'b0;
    chk("rstw_wen_on", 32'(ram_wen), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("rstw_wen_async", 32'(ram_wen), 32'd0);
    chk("rstw_ready_async", 32'(cmd_ready), 32'd1);
    snap_done = done_cnt;
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rstw_no_done", 32'(done_cnt), 32'(snap_done));
    chk("rstw_ready", 32'(cmd_ready), 32'd1);
    lat = 2;
    exp_q.push_back(32'h5A5A5A5A);
    send_cmd(1'b0, 13'h060, 4'd0);
    read_burst("post_rst", 4'd0, -1, 0);

    chk("req_gap_viol", 32'(viol), 32'd0);
    chk("done_err_overlap", 32'(overlap), 32'd0);
    chk("err_total", 32'(err_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
